switch_ctrl: RTL
================

# switch_ctrl

Per-router switch controller for the Phoenix NoC. It arbitrates among input buffers that present a packet header and computes the XY route for the winner. It then allocates the requested output port and keeps the connection tables and free flags that drive the crossbar. A connection is released automatically when its input buffer stops sending.

## Interface
Parameters (from `defines.vh`): `NPORT` = 5, `TAM_FLIT` = 16, `reg3` = 3, `NP_REGF` = `NPORT*TAM_FLIT`, `NP_REG3` = `NPORT*reg3`, port indices `EAST`=0, `WEST`=1, `NORTH`=2, `SOUTH`=3, `LOCAL`=4.

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `i_h`  in  `NPORT`  header present at input buffer i
- `i_data_t`  in  `NP_REGF`  packed head flit of each input buffer
- `i_sender`  in  `NPORT`  input buffer i is still transmitting its packet
- `i_address`  in  `TAM_FLIT/2`  this router's address: X in [7:4], Y in [3:0]
- `o_ack_h`  out  `NPORT`  one-cycle grant acknowledge to input i
- `o_free`  out  `NPORT`  output port o is unallocated
- `o_tab_in_t`  out  `NP_REG3`  packed: output port connected to input i
- `o_tab_out_t`  out  `NP_REG3`  packed: input port driving output o

## Operation
- The FSM has four states: IDLE, ARB, ROUTE and ACK.
- IDLE: if any `i_h` bit is set, go to ARB; otherwise stay.
- ARB: scan from `ptr+1` upward, wrapping LOCAL→EAST. Register the first i with `i_h[i]=1` as `sel`. Go to ROUTE. If no `i_h` bit is set, return to IDLE.
- ROUTE:
  - Take target `tx = head[7:4]` and `ty = head[3:0]` from `i_data_t[sel]`. Take `lx` and `ly` from `i_address`.
  - Compute `dir`, checking these rules in order:
    - `tx>lx` gives EAST.
    - `tx<lx` gives WEST.
    - `ty>ly` gives NORTH.
    - `ty<ly` gives SOUTH.
    - Otherwise LOCAL.
  - All comparisons are unsigned 4-bit.
  - If `o_free[dir]=1`: set `tab_in[sel]=dir`, `tab_out[dir]=sel` and `free[dir]=0`, then go to ACK.
  - If `o_free[dir]=0`: go to IDLE. No ack is issued, and the header is retried later.
  - In both cases `ptr<=sel`.
- ACK: `o_ack_h[sel]=1` for exactly this cycle, then go to IDLE.
- Release runs every cycle independently of the FSM. For each output o with `free[o]=0` and `i_sender[tab_out[o]]=0`, set `free[o]<=1`. Table entries are not cleared on release.
- Grant and release never target the same output on one edge, because a grant requires `free=1`.
- A U-turn (input equal to output, e.g. LOCAL→LOCAL) is legal.

## Timing
- Reset values:
  - `o_free` all 1
  - `o_tab_in_t` and `o_tab_out_t` all 0
  - `o_ack_h` 0
  - state IDLE
  - `ptr=LOCAL`, so the first scan starts at EAST
- Reset mid-packet drops all connections immediately.
- Grant latency: if `i_h` is sampled high in IDLE at edge T, `o_ack_h` is high in the cycle after edge T+2. The tables and `o_free` are updated on that same edge (T+2).
- A failed route consumes 3 cycles. The next arbitration begins after IDLE.
- Release: `i_sender` sampled low at edge T makes `o_free` high after edge T. A new grant for that output can then occur from the next ROUTE.
- Handshake: the requester must hold `i_h` and the head flit stable until `o_ack_h`. Requester and connection outputs are all registered, and there are no combinational paths from input to output.

## Configuration
- `SWC_ROUND_ROBIN_EN` defined: rotating priority as described, with `ptr` updated after every ROUTE.
- `SWC_ROUND_ROBIN_EN` undefined: fixed priority, with the lowest index winning (EAST highest). `ptr` is not implemented and the scan always starts at EAST.

## Structure
- Port indices, `NPORT`, `reg3`, `TAM_FLIT`, the packed widths and the FSM state encodings belong in `defines.vh`.
- One sub-module, `xy_route`, is natural: a combinational mapping from (`tx`,`ty`,`lx`,`ly`) to a 3-bit `dir`.
- The arbiter scan and the FSM stay inline.

## Test plan
- Local address 0x11; LOCAL head 0x0031; `i_sender[LOCAL]=1` → `o_ack_h[4]` high at cycle 3; `tab_out[EAST]=4`; `tab_in[LOCAL]=0`; `o_free[EAST]=0`.
- Same setup, then drop `i_sender[LOCAL]` → `o_free[EAST]=1` one cycle later.
- WEST and NORTH both request EAST simultaneously, with senders held → only the first winner is acked. The second retries until the first releases, then is acked.
- All five inputs request distinct outputs continuously (`SWC_ROUND_ROBIN_EN`) → grant order EAST, WEST, NORTH, SOUTH, LOCAL, each 4 cycles apart. Without the macro, with EAST re-requesting after every release, EAST always wins.
- Head targets equal to the local address (0x0011) from EAST → `dir=LOCAL`; `tab_in[EAST]=4`.
- Assert `reset` during ACK with two connections held → next cycle `o_free=5'b11111`, `o_ack_h=0`, tables zero.

Source files
------------

// File: rtl/switch_ctrl_pkg.sv
// Shared definitions for the Phoenix NoC switch controller: port indices,
// packed bus widths and FSM state encoding.
package switch_ctrl_pkg;

  localparam int unsigned NPORT    = 5;
  localparam int unsigned TAM_FLIT = 16;
  localparam int unsigned reg3     = 3;
  localparam int unsigned NP_REGF  = NPORT * TAM_FLIT;
  localparam int unsigned NP_REG3  = NPORT * reg3;

  localparam logic [reg3-1:0] EAST  = 3'd0;
  localparam logic [reg3-1:0] WEST  = 3'd1;
  localparam logic [reg3-1:0] NORTH = 3'd2;
  localparam logic [reg3-1:0] SOUTH = 3'd3;
  localparam logic [reg3-1:0] LOCAL = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_ROUTE,
    S_ACK
  } state_t;

  // Port following p in scan order, wrapping LOCAL back to EAST.
  function automatic logic [reg3-1:0] next_port(input logic [reg3-1:0] p);
    return (p == LOCAL) ? EAST : p + 3'd1;
  endfunction

endpackage

// File: rtl/switch_ctrl_xy_route.sv
// XY routing decision: resolve X first, then Y, otherwise deliver locally.
module xy_route
  import switch_ctrl_pkg::*;
(
  input  logic [3:0]      tx,
  input  logic [3:0]      ty,
  input  logic [3:0]      lx,
  input  logic [3:0]      ly,
  output logic [reg3-1:0] dir
);

  // Ordered unsigned comparisons select the output direction.
  always_comb begin
    if (tx > lx)      dir = EAST;
    else if (tx < lx) dir = WEST;
    else if (ty > ly) dir = NORTH;
    else if (ty < ly) dir = SOUTH;
    else              dir = LOCAL;
  end

endmodule

// File: rtl/switch_ctrl.sv
// Phoenix NoC switch controller: arbitrates header requests, routes the
// winner with XY routing, allocates the output port and releases it when
// the input stops sending.
// Build option: SWC_ROUND_ROBIN_EN selects rotating priority; otherwise
// fixed priority with EAST highest.
module switch_ctrl
  import switch_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NPORT-1:0]      i_h,
  input  logic [NP_REGF-1:0]    i_data_t,
  input  logic [NPORT-1:0]      i_sender,
  input  logic [TAM_FLIT/2-1:0] i_address,
  output logic [NPORT-1:0]      o_ack_h,
  output logic [NPORT-1:0]      o_free,
  output logic [NP_REG3-1:0]    o_tab_in_t,
  output logic [NP_REG3-1:0]    o_tab_out_t
);

  state_t              state, state_nxt;
  logic [reg3-1:0]     sel, sel_nxt, scan_start, dir;
  logic                found;
  logic                do_arb, do_grant;
  int unsigned         idx;
  logic [TAM_FLIT-1:0] head;
  logic                unused_head_hi;
  logic [NPORT-1:0]    free, ack_h;
  logic [reg3-1:0]     tab_in  [NPORT];
  logic [reg3-1:0]     tab_out [NPORT];

`ifdef SWC_ROUND_ROBIN_EN
  logic [reg3-1:0] ptr;

  // Rotating priority pointer: last routed input becomes lowest priority.
  always_ff @(posedge clock) begin
    if (reset)                 ptr <= LOCAL;
    else if (state == S_ROUTE) ptr <= sel;
  end

  assign scan_start = next_port(ptr);
`else
  assign scan_start = EAST;
`endif

  // Arbiter scan: first requesting input at or after scan_start, wrapping.
  always_comb begin
    found   = 1'b0;
    sel_nxt = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      idx = 32'(scan_start) + k;
      if (idx >= NPORT) idx = idx - NPORT;
      if (!found && i_h[idx]) begin
        found   = 1'b1;
        sel_nxt = 3'(idx);
      end
    end
  end

  assign head           = i_data_t[32'(sel)*TAM_FLIT +: TAM_FLIT];
  assign unused_head_hi = ^head[15:8];

  xy_route u_xy_route (
    .tx  (head[7:4]),
    .ty  (head[3:0]),
    .lx  (i_address[7:4]),
    .ly  (i_address[3:0]),
    .dir (dir)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = (|i_h) ? S_ARB : S_IDLE;
      S_ARB:   state_nxt = found ? S_ROUTE : S_IDLE;
      S_ROUTE: state_nxt = free[dir] ? S_ACK : S_IDLE;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode driving the datapath registers.
  always_comb begin
    do_arb   = (state == S_ARB) && found;
    do_grant = (state == S_ROUTE) && free[dir];
  end

  // Selection, grant, connection tables and per-output release.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel   <= '0;
      ack_h <= '0;
      free  <= '1;
      for (int unsigned k = 0; k < NPORT; k++) begin
        tab_in[k]  <= '0;
        tab_out[k] <= '0;
      end
    end else begin
      if (do_arb) sel <= sel_nxt;
      ack_h <= '0;
      for (int unsigned o = 0; o < NPORT; o++) begin
        if (!free[o] && !i_sender[tab_out[o]]) free[o] <= 1'b1;
      end
      // A grant only targets a free output, so it never collides with a release.
      if (do_grant) begin
        tab_in[sel]  <= dir;
        tab_out[dir] <= sel;
        free[dir]    <= 1'b0;
        ack_h[sel]   <= 1'b1;
      end
    end
  end

  // Pack connection tables onto the crossbar control buses.
  always_comb begin
    for (int unsigned k = 0; k < NPORT; k++) begin
      o_tab_in_t[k*reg3 +: reg3]  = tab_in[k];
      o_tab_out_t[k*reg3 +: reg3] = tab_out[k];
    end
  end

  assign o_free  = free;
  assign o_ack_h = ack_h;

endmodule
